gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, named rst.
REQ-002 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2-16).
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable, one step per cycle while high.
REQ-006 The block SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down; sampled only when en = 1.
REQ-007 The block SHALL have port load, input, 1 bit: load the counter from load_gray.
REQ-008 The block SHALL have port load_gray, input, WIDTH bits: Gray-coded load value.
REQ-009 The block SHALL have port gray, output, WIDTH bits: registered Gray-coded count.
REQ-010 The block SHALL have port binary, output, WIDTH bits: registered binary equivalent of gray, same cycle.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on a count wrap.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 Internal state SHALL be a WIDTH-bit binary count B; gray SHALL equal B ^ (B >> 1) at every clock edge.
REQ-014 Per-edge priority SHALL be rst > load > en; with none asserted, all state holds and wrap = 0.
REQ-015 On load = 1: B <= Gray-to-binary of load_gray (b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i]); gray <= load_gray; wrap <= 0; en and up_dn are ignored that cycle.
REQ-016 On en = 1, up_dn = 1: B <= B + 1 modulo 2^WIDTH.
REQ-017 On en = 1, up_dn = 0: B <= B - 1 modulo 2^WIDTH.
REQ-018 wrap SHALL be 1 for exactly the cycle after an up step from all-ones to zero or a down step from zero to all-ones; otherwise 0.
REQ-019 Every enabled step SHALL change exactly one bit of gray, including wrap steps.
REQ-020 Direction changes SHALL take effect on the next enabled step with no idle cycle.
REQ-021 Latency SHALL be 1 cycle: inputs sampled at edge N appear on gray, binary and wrap after edge N.

Reset
REQ-022 When rst = 1 at a clock edge: gray <= 0, binary <= 0, wrap <= 0, regardless of load and en.
REQ-023 Reset mid-count SHALL discard the current value; counting resumes from 0 on the first enabled cycle after rst falls.
REQ-024 Before the first reset edge, output values are undefined; the bench SHALL apply rst for at least 2 cycles before checking.

Verification
REQ-025 Reset: rst = 1 for 2 cycles, en = 1, load = 1 -> gray = 0000, binary = 0000, wrap = 0.
REQ-026 Up sweep (WIDTH = 4): en = 1, up_dn = 1 for 16 cycles from 0 -> gray sequence 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000; binary tracks 1..15, 0; wrap = 1 only on the final step; exactly one bit changes per step.
REQ-027 Down wrap: from 0, en = 1, up_dn = 0 for 1 cycle -> gray = 1000, binary = 1111, wrap = 1; next down step -> gray = 1001, binary = 1110, wrap = 0.
REQ-028 Load priority: load = 1, load_gray = 1100, en = 1, up_dn = 1 in the same cycle -> gray = 1100, binary = 1000, wrap = 0; next enabled up step -> gray = 1101, binary = 1001.
REQ-029 Hold and reset mid-count: at binary = 0101, en = 0 for 3 cycles -> gray = 0111 held, wrap = 0; then rst = 1 with en = 1 -> gray = 0000; rst = 0 with en = 1 -> gray = 0001.
REQ-030 Self-check: each cycle, the bench SHALL compare binary against an independent Gray-to-binary model of gray and flag any mismatch.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with parallel Gray load.
// The count is held internally in binary; the Gray and binary outputs are
// both registered copies of it, so there is no combinational path from any
// input to any output.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Next count for an enabled step, plus the wrap flag for that step.
    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (up_dn) begin
            bin_next  = bin_q + ONE;
            wrap_next = (bin_q == ALL_ONES);
        end else begin
            bin_next  = bin_q - ONE;
            wrap_next = (bin_q == ZERO);
        end
        gray_next = bin_to_gray(bin_next);
        load_bin  = gray_to_bin(load_gray);
    end

    // Counter state: reset beats load, load beats counting, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (load) begin
            bin_q  <= load_bin;
            gray_q <= load_gray;
            wrap_q <= 1'b0;
        end else if (en) begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign gray   = gray_q;
    assign binary = bin_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (WIDTH = 4) using directed vectors.
// Stimulus pushes hand-computed expectations into a queue; an independent
// monitor pops one entry per clock and compares all outputs.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_gray;
    logic [3:0] gray;
    logic [3:0] binary;
    logic       wrap;

    typedef struct {
        logic [3:0] g;
        logic [3:0] b;
        logic       w;
        logic       step;
        string      name;
    } exp_t;

    exp_t expQ[$];

    int errors = 0;
    int checks = 0;

    logic [3:0] upGray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

    gray_counter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_gray (load_gray),
        .gray      (gray),
        .binary    (binary),
        .wrap      (wrap)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Gray to binary reference, walking down from the MSB.
    function automatic logic [3:0] tbGrayToBin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    task automatic checkOutput(input string nm, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", nm, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and queue the
    // response expected after the following edge.
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [3:0] lg,
                                 input logic [3:0] eg, input logic [3:0] eb,
                                 input logic ew, input logic st,
                                 input string nm);
        exp_t x;
        @(posedge clk);
        #2;
        rst       = r;
        en        = e;
        up_dn     = u;
        load      = l;
        load_gray = lg;
        x.g    = eg;
        x.b    = eb;
        x.w    = ew;
        x.step = st;
        x.name = nm;
        expQ.push_back(x);
    endtask

    // Monitor: one output set per clock, compared against the queue head.
    initial begin : monitor
        exp_t       x;
        logic [3:0] prevGray;
        prevGray = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput({x.name, ".gray"},   {12'd0, gray},   {12'd0, x.g});
                checkOutput({x.name, ".binary"}, {12'd0, binary}, {12'd0, x.b});
                checkOutput({x.name, ".wrap"},   {15'd0, wrap},   {15'd0, x.w});
                checkOutput({x.name, ".g2b"},    {12'd0, binary},
                            {12'd0, tbGrayToBin(gray)});
                if (x.step) begin
                    checkOutput({x.name, ".onebit"}, 16'($countones(gray ^ prevGray)),
                                16'd1);
                end
                prevGray = gray;
            end
        end
    end

    // Directed sequence.
    initial begin : stimulus
        int waitCycles;
        rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_gray = 4'b1111;

        // Reset wins over load and en.
        applyStimulus(1, 1, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, "rst0");
        applyStimulus(1, 1, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, "rst1");

        // Full up sweep with wrap on the last step.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 1, 0, 4'b0000, upGray[i], 4'((i + 1) % 16),
                          (i == 15), 1, $sformatf("up%0d", i));
        end

        // Down wrap from zero, then an ordinary down step.
        applyStimulus(0, 1, 0, 0, 4'b0000, 4'b1000, 4'b1111, 1, 1, "dnwrap");
        applyStimulus(0, 1, 0, 0, 4'b0000, 4'b1001, 4'b1110, 0, 1, "dn1");

        // Load beats a simultaneous up step, then count up from it.
        applyStimulus(0, 1, 1, 1, 4'b1100, 4'b1100, 4'b1000, 0, 0, "load");
        applyStimulus(0, 1, 1, 0, 4'b0000, 4'b1101, 4'b1001, 0, 1, "ldup");
        // Immediate direction change.
        applyStimulus(0, 1, 0, 0, 4'b0000, 4'b1100, 4'b1000, 0, 1, "turn");

        // Load all-ones (gray 1000) without wrap, then wrap upward.
        applyStimulus(0, 0, 1, 1, 4'b1000, 4'b1000, 4'b1111, 0, 0, "ldmax");
        applyStimulus(0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, "upwrap");

        // Load binary 0101, hold three cycles, reset mid-count, resume.
        applyStimulus(0, 0, 1, 1, 4'b0111, 4'b0111, 4'b0101, 0, 0, "ld5");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 4'b0000, 4'b0111, 4'b0101, 0, 0,
                          $sformatf("hold%0d", i));
        end
        applyStimulus(1, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, "midrst");
        applyStimulus(0, 1, 1, 0, 4'b0000, 4'b0001, 4'b0001, 0, 1, "resume");

        // Quiet cycle: hold, wrap stays low.
        applyStimulus(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 0, 0, "idle");

        // Let the monitor drain the queue, bounded.
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #3;
        if (expQ.size() > 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
